aes_round_controller: RTL and testbench

- Sequences one AES-128 encryption through the existing key schedule block and the round datapath.
- Triggers key expansion once after reset or re-key.
- Per round, drives the key schedule's key-select input and waits for the selected key to settle.
- Then pulses the matching datapath strobe: initial AddRoundKey, mid round, or final round.
- Sits between the host start/done handshake, the key schedule (En/SelKey/Ry) and the round datapath.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_round_controller_if.sv | 28 ++
 rtl/aes_wait_timer.sv | 25 ++
 rtl/aes_round_controller.sv | 150 +++++++++++++++
 tb/tb_aes_round_controller.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller and the round datapath.
// Holds the round count, the controller state encoding and the round-type
// constants that tell the datapath which flavour of round to run.
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam int RND_W      = 4;   // round index / key select width
  localparam int TMR_W      = 8;   // wait / expansion timeout counter width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXPAND = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RT_LOAD  = 2'd0,   // input block XOR key 0
    RT_MID   = 2'd1,   // full round with MixColumns
    RT_FINAL = 2'd2    // last round, no MixColumns
  } round_type_e;

  function automatic round_type_e round_type(input logic [RND_W-1:0] rnd);
    if (rnd == '0)                        return RT_LOAD;
    else if (rnd >= RND_W'(NUM_ROUNDS))   return RT_FINAL;
    else                                  return RT_MID;
  endfunction
endpackage

// File: rtl/aes_round_controller_if.sv
// Handshake bundle around the round controller: host start/done, the key
// schedule (En/SelKey/Ry) and the round datapath strobes.
//   slave  : the controller side
//   master : the host / key schedule / datapath environment side
interface aes_round_controller_if;
  import aes_pkg::*;
  logic             Start;
  logic             Rekey;
  logic             KsRy;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic             KsEn;
  logic [RND_W-1:0] KsSelKey;
  logic             DpLoad;
  logic             DpRound;
  logic             DpFinal;
  logic [RND_W-1:0] RoundCnt;

  modport slave (
    input  Start, Rekey, KsRy,
    output Busy, Done, Error, KsEn, KsSelKey, DpLoad, DpRound, DpFinal, RoundCnt
  );
  modport master (
    output Start, Rekey, KsRy,
    input  Busy, Done, Error, KsEn, KsSelKey, DpLoad, DpRound, DpFinal, RoundCnt
  );
endinterface

// File: rtl/aes_wait_timer.sv
// Loadable down-counter with a terminal flag.
//   clk, rst : clock, async active-high reset
//   load     : load load_val (wins over en)
//   en       : decrement by one; holds at zero, never wraps
//   last     : count is 1 (or 0), i.e. this is the final cycle of the delay
module aes_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign last = (cnt <= W'(1));
endmodule

// File: rtl/aes_round_controller.sv
// Sequences one AES-128 block: key expansion (once after reset / re-key),
// then for each round selects the round key, lets it settle for KEY_WAIT
// cycles and fires exactly one datapath strobe.
//   Clk, Rst : clock, async active-high reset
//   bus      : slave side of aes_round_controller_if (host, key schedule,
//              datapath strobes, status)
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int KEY_WAIT    = 1,
  parameter int EXP_TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  aes_round_controller_if.slave bus
);
  localparam logic [TMR_W-1:0] KW_V = TMR_W'(KEY_WAIT);
  localparam logic [TMR_W-1:0] ET_V = TMR_W'(EXP_TIMEOUT);
  localparam logic [RND_W-1:0] NR_V = RND_W'(NUM_ROUNDS);

  state_e           state, state_nxt;
  logic [RND_W-1:0] rnd;
  logic             keys_ready, rekey_pend, err;

  logic             tmr_load, tmr_en, tmr_last;
  logic [TMR_W-1:0] tmr_val;
  logic             accept, rnd_clr, rnd_inc, keys_set, err_set;

  // One timer serves both the key settle delay and the expansion timeout;
  // the two never overlap.
  aes_wait_timer #(.W(TMR_W)) u_tmr (
    .clk(Clk), .rst(Rst), .load(tmr_load), .en(tmr_en),
    .load_val(tmr_val), .last(tmr_last)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = KW_V;
    accept    = 1'b0;
    rnd_clr   = 1'b0;
    rnd_inc   = 1'b0;
    keys_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: if (bus.Start) begin
        accept   = 1'b1;
        rnd_clr  = 1'b1;
        tmr_load = 1'b1;
        // A Rekey arriving together with Start counts as already pending.
        if (keys_ready && !rekey_pend && !bus.Rekey) state_nxt = ST_WAIT;
        else begin
          state_nxt = ST_EXPAND;
          tmr_val   = ET_V;
        end
      end
      ST_EXPAND: begin
        // Ready beats a coincident timeout.
        if (bus.KsRy) begin
          keys_set  = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = ST_WAIT;
        end else if (tmr_last) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else tmr_en = 1'b1;
      end
      ST_WAIT: begin
        if (tmr_last) state_nxt = ST_EXEC;
        else          tmr_en    = 1'b1;
      end
      ST_EXEC: begin
        if (rnd >= NR_V) state_nxt = ST_DONE;
        else begin
          rnd_inc   = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        rnd_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rnd        <= '0;
      keys_ready <= 1'b0;
      rekey_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (rnd_clr)                     rnd <= '0;
      else if (rnd_inc && rnd < NR_V)  rnd <= rnd + 1'b1;

      if (keys_set)                                   keys_ready <= 1'b1;
      else if (accept && state_nxt == ST_EXPAND)      keys_ready <= 1'b0;

      // Rekey during a block only marks the keys stale for the next Start.
      if (accept)          rekey_pend <= 1'b0;
      else if (bus.Rekey)  rekey_pend <= 1'b1;

      if (err_set)      err <= 1'b1;
      else if (accept)  err <= 1'b0;
    end
  end

  always_comb begin
    bus.Busy     = 1'b0;
    bus.Done     = 1'b0;
    bus.KsEn     = 1'b0;
    bus.KsSelKey = '0;
    bus.DpLoad   = 1'b0;
    bus.DpRound  = 1'b0;
    bus.DpFinal  = 1'b0;
    case (state)
      ST_EXPAND: begin
        bus.Busy = 1'b1;
        bus.KsEn = 1'b1;
      end
      ST_WAIT: begin
        bus.Busy     = 1'b1;
        bus.KsSelKey = rnd;
      end
      ST_EXEC: begin
        bus.Busy     = 1'b1;
        bus.KsSelKey = rnd;
        case (round_type(rnd))
          RT_LOAD:  bus.DpLoad  = 1'b1;
          RT_MID:   bus.DpRound = 1'b1;
          RT_FINAL: bus.DpFinal = 1'b1;
          default:  ;
        endcase
      end
      ST_DONE: bus.Done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Error    = err;
  assign bus.RoundCnt = rnd;
endmodule

// File: tb/tb_aes_round_controller.sv
module tb_aes_round_controller;
  import aes_pkg::*;
  localparam int NR = NUM_ROUNDS;
  localparam int ET = 255;

  // observation vector bit positions
  localparam int B_BUSY = 14, B_DONE = 13, B_ERR = 12, B_KSEN = 11;
  localparam int B_LD = 6, B_RD = 5, B_FN = 4;
  typedef logic [14:0] obs_t;

  logic Clk = 1'b0, Rst = 1'b0;
  logic start = 1'b0, rekey = 1'b0, ksry = 1'b0;
  always #5 Clk = ~Clk;

  aes_round_controller_if ifa ();
  aes_round_controller_if ifb ();
  assign ifa.Start = start; assign ifa.Rekey = rekey; assign ifa.KsRy = ksry;
  assign ifb.Start = start; assign ifb.Rekey = rekey; assign ifb.KsRy = ksry;

  aes_round_controller #(.KEY_WAIT(1), .EXP_TIMEOUT(ET)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
  aes_round_controller #(.KEY_WAIT(3), .EXP_TIMEOUT(ET)) dut_b (.Clk(Clk), .Rst(Rst), .bus(ifb));

  obs_t act [2];
  assign act[0] = {ifa.Busy, ifa.Done, ifa.Error, ifa.KsEn, ifa.KsSelKey,
                   ifa.DpLoad, ifa.DpRound, ifa.DpFinal, ifa.RoundCnt};
  assign act[1] = {ifb.Busy, ifb.Done, ifb.Error, ifb.KsEn, ifb.KsSelKey,
                   ifb.DpLoad, ifb.DpRound, ifb.DpFinal, ifb.RoundCnt};

  // ---------------- behavioural model ----------------
  // A block is an offset k from its first key-select cycle; each round spans
  // KEY_WAIT+1 cycles with the strobe on the last one, Done follows the last.
  int kw [2] = '{1, 3};
  bit m_keys [2], m_pend [2], m_err [2], m_exp [2], m_blk [2];
  int m_en [2], m_k [2];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 2; i++) begin
        m_keys[i] <= 0; m_pend[i] <= 0; m_err[i] <= 0;
        m_exp[i] <= 0; m_blk[i] <= 0; m_en[i] <= 0; m_k[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_exp[i]) begin
          if (rekey) m_pend[i] <= 1;
          if (ksry) begin
            m_keys[i] <= 1; m_exp[i] <= 0; m_blk[i] <= 1; m_k[i] <= 0;
          end else if (m_en[i] == ET) begin
            m_err[i] <= 1; m_exp[i] <= 0;
          end else m_en[i] <= m_en[i] + 1;
        end else if (m_blk[i]) begin
          if (rekey) m_pend[i] <= 1;
          if (m_k[i] == (NR + 1) * (kw[i] + 1)) m_blk[i] <= 0;
          else m_k[i] <= m_k[i] + 1;
        end else if (start) begin
          m_err[i] <= 0; m_pend[i] <= 0;
          if (!m_keys[i] || m_pend[i] || rekey) begin
            m_keys[i] <= 0; m_exp[i] <= 1; m_en[i] <= 1;
          end else begin
            m_blk[i] <= 1; m_k[i] <= 0;
          end
        end else if (rekey) m_pend[i] <= 1;
      end
    end
  end

  function automatic obs_t model_out(int i);
    int L, n, r;
    logic busy, done, ksen, ld, rd, fn;
    logic [3:0] sel, rc;
    L = kw[i] + 1; n = (NR + 1) * L;
    busy = 0; done = 0; ksen = 0; ld = 0; rd = 0; fn = 0; sel = 0; rc = 0;
    if (m_exp[i]) begin
      busy = 1; ksen = 1;
    end else if (m_blk[i]) begin
      if (m_k[i] < n) begin
        r = m_k[i] / L; busy = 1; sel = 4'(r); rc = 4'(r);
        if (m_k[i] % L == kw[i]) begin
          if (r == 0) ld = 1; else if (r == NR) fn = 1; else rd = 1;
        end
      end else begin
        done = 1; rc = 4'(NR);
      end
    end
    return {busy, done, m_err[i], ksen, sel, ld, rd, fn, rc};
  endfunction

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0;
  int ev_ksen_last [2], ev_load [2], ev_final [2], ev_done [2];
  int n_done [2], n_round [2], n_strobe [2], n_ksen_rise [2];
  int b_done [2], b_round [2], b_strobe [2], b_ksen [2];
  bit prev_ksen [2] = '{0, 0};

  task automatic check(string name, int a, int e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end
  endtask

  task automatic check_obs(string name, obs_t a, obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, a, e);
    end
  endtask

  // One cycle: compare every output against the model at the falling edge,
  // log events, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check_obs(i == 0 ? "outputs a" : "outputs b", act[i], model_out(i));
      if (act[i][B_KSEN] && !prev_ksen[i]) n_ksen_rise[i]++;
      if (act[i][B_KSEN]) ev_ksen_last[i] = cyc;
      prev_ksen[i] = act[i][B_KSEN];
      if (act[i][B_LD]) ev_load[i] = cyc;
      if (act[i][B_FN]) ev_final[i] = cyc;
      if (act[i][B_RD]) n_round[i]++;
      if (act[i][B_LD] | act[i][B_RD] | act[i][B_FN]) n_strobe[i]++;
      if (act[i][B_DONE]) begin ev_done[i] = cyc; n_done[i]++; end
    end
    @(posedge Clk); #2;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_done[i] = n_done[i]; b_round[i] = n_round[i];
      b_strobe[i] = n_strobe[i]; b_ksen[i] = n_ksen_rise[i];
    end
  endtask

  task automatic go();   // Start high for exactly cycle 0
    snap(); t0 = cyc; start = 1; tick(); start = 0;
  endtask

  initial begin
    #1 Rst = 1;
    tick(); tick();
    check_obs("reset a", act[0], '0);
    check_obs("reset b", act[1], '0);
    Rst = 0; tick();

    // cold start: expansion, KsRy in cycle 4
    go(); run(3);
    ksry = 1; tick(); ksry = 0;
    run(55);
    check("t1 ksen rise a", n_ksen_rise[0] - b_ksen[0], 1);
    check("t1 ksen last a", ev_ksen_last[0] - t0, 4);
    check("t1 load a", ev_load[0] - t0, 6);
    check("t1 final a", ev_final[0] - t0, 26);
    check("t1 done a", ev_done[0] - t0, 27);
    check("t1 done b", ev_done[1] - t0, 49);

    // keys ready: no expansion
    go(); run(50);
    check("t2 ksen rises a", n_ksen_rise[0] - b_ksen[0], 0);
    check("t2 load a", ev_load[0] - t0, 2);
    check("t2 rounds a", n_round[0] - b_round[0], 9);
    check("t2 strobes a", n_strobe[0] - b_strobe[0], 11);
    check("t2 final a", ev_final[0] - t0, 22);
    check("t2 done a", ev_done[0] - t0, 23);
    check("t2 load b", ev_load[1] - t0, 4);
    check("t2 rounds b", n_round[1] - b_round[1], 9);
    check("t2 done b", ev_done[1] - t0, 45);

    // expansion timeout (Rekey with Start forces EXPAND)
    snap(); t0 = cyc; start = 1; rekey = 1; tick(); start = 0; rekey = 0;
    run(260);
    check("t3 error a", act[0][B_ERR], 1);
    check("t3 error b", act[1][B_ERR], 1);
    check("t3 busy a", act[0][B_BUSY], 0);
    check("t3 ksen last a", ev_ksen_last[0] - t0, 255);
    check("t3 no done a", n_done[0] - b_done[0], 0);
    check("t3 no strobes a", n_strobe[0] - b_strobe[0], 0);
    go();
    check("t3 error cleared a", act[0][B_ERR], 0);
    check("t3 error cleared b", act[1][B_ERR], 0);
    tick(); ksry = 1; tick(); ksry = 0;
    run(50);
    check("t3 recover done a", ev_done[0] - t0, 25);
    check("t3 recover done b", ev_done[1] - t0, 47);

    // Start while busy ignored; Rekey in round 5 defers to next block
    go(); run(3);
    start = 1; tick(); start = 0;
    run(6);
    rekey = 1; tick(); rekey = 0;
    run(40);
    check("t4 done a", ev_done[0] - t0, 23);
    check("t4 one done a", n_done[0] - b_done[0], 1);
    check("t4 done b", ev_done[1] - t0, 45);
    check("t4 one done b", n_done[1] - b_done[1], 1);
    go(); tick();
    check("t4 reexpand a", act[0][B_KSEN], 1);
    check("t4 reexpand b", act[1][B_KSEN], 1);
    ksry = 1; tick(); ksry = 0;
    run(50);
    check("t4 done after rekey a", ev_done[0] - t0, 25);

    // async reset mid-WAIT at round 4
    go(); run(8);
    check("t5 round a", int'(act[0][3:0]), 4);
    Rst = 1; #1;
    check_obs("t5 async reset a", act[0], '0);
    check_obs("t5 async reset b", act[1], '0);
    tick(); Rst = 0;
    run(30);
    check("t5 no done a", n_done[0] - b_done[0], 0);
    go(); tick();
    check("t5 reexpand a", act[0][B_KSEN], 1);
    ksry = 1; tick(); ksry = 0;
    run(50);
    check("t5 done a", ev_done[0] - t0, 25);
    check("t5 done b", ev_done[1] - t0, 47);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
